// File: rtl/dmem_ctrl.sv
// Data-memory stage: one fixed-latency load/store per request against an internal 2^AW x DW array.
// Optional write protection of addresses >= PROT_BASE is enabled by defining DMEM_WPROT_EN.
module dmem_ctrl #(
    parameter int unsigned   DW        = 8,
    parameter int unsigned   AW        = 8,
    parameter int unsigned   LATENCY   = 2,
    parameter logic [AW-1:0] PROT_BASE = AW'(8'hF0)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic          req,
    input  logic          wr,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          done,
    output logic          err
);

`ifdef DMEM_WPROT_EN
    localparam bit WPROT_EN = 1'b1;
`else
    localparam bit WPROT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    cnt;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          wr_q;
    logic          reject_q;
    logic          accept;
    logic          commit;
    logic          wr_reject;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    assign accept    = req && (state == IDLE || state == DONE);
    assign commit    = (state == WAIT) && (cnt == 4'd0);
    assign wr_reject = WPROT_EN && (addr_q >= PROT_BASE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = accept ? WAIT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            reject_q <= 1'b0;
            rdata    <= '0;
        end else begin
            if (accept) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                wr_q    <= wr;
                cnt     <= 4'(LATENCY - 1);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                if (!wr_q) begin
                    rdata <= mem[addr_q];
                end
                reject_q <= wr_q && wr_reject;
            end
        end
    end

    // The array has no reset, so reset must gate the write explicitly to drop a pending store.
    always_ff @(posedge clk) begin
        if (!reset && commit && wr_q && !wr_reject) begin
            mem[addr_q] <= wdata_q;
        end
    end

    always_comb begin
        busy = (state == WAIT);
        done = (state == DONE);
        err  = (state == DONE) && reject_q;
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed vector table, reset/throughput sequences,
// and randomized accesses against an associative-array memory model.
module tb_dmem_ctrl;

    localparam int unsigned LAT = 2;
`ifdef DMEM_WPROT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       req;
    logic       wr;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       err;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] mdl [int];
    logic [7:0] rd_hold;
    bit         hold_valid;

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        bit         rd_valid;
        bit         exp_err;
    } vec_t;

    vec_t vt [14];

    dmem_ctrl #(
        .DW       (8),
        .AW       (8),
        .LATENCY  (LAT),
        .PROT_BASE(8'hF0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .wdata(wdata),
        .req  (req),
        .wr   (wr),
        .rdata(rdata),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_err", err, 0);
            if (hold_valid) chk("idle_rdata", rdata, rd_hold);
        end
    endtask

    // Called just after an edge with the DUT in IDLE or DONE; returns just after the DONE edge.
    task automatic do_access(input bit w, input logic [7:0] a, input logic [7:0] d,
                             input logic [7:0] exp_rd, input bit rd_valid,
                             input bit exp_err, input bit noisy);
        req = 1'b1; wr = w; addr = a; wdata = d;
        @(posedge clk); #1;
        chk("wait_busy", busy, 1);
        chk("wait_done", done, 0);
        for (int k = 1; k < int'(LAT); k++) begin
            req   = noisy ? 1'($urandom) : 1'b0;
            wr    = 1'($urandom);
            addr  = 8'($urandom);
            wdata = 8'($urandom);
            @(posedge clk); #1;
            chk("wait_busy", busy, 1);
            chk("wait_done", done, 0);
            chk("wait_err", err, 0);
        end
        req = 1'b0; addr = 8'($urandom); wdata = 8'($urandom);
        @(posedge clk); #1;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_err", err, 32'(exp_err));
        if (rd_valid) chk(w ? "rdata_hold" : "rdata_load", rdata, exp_rd);
    endtask

    initial begin
        logic [7:0] er;
        bit         ev;
        bit         w;
        logic [7:0] a;
        logic [7:0] d;
        bit         rej;

        vt[0]  = '{1'b1, 8'h10, 8'h5A, 8'h00, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 8'h10, 8'h00, 8'h5A, 1'b1, 1'b0};
        vt[2]  = '{1'b1, 8'h20, 8'h33, 8'h00, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 8'h20, 8'h00, 8'h33, 1'b1, 1'b0};
        vt[4]  = '{1'b1, 8'h00, 8'hC3, 8'h00, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 8'h00, 8'h00, 8'hC3, 1'b1, 1'b0};
        vt[6]  = '{1'b1, 8'hEF, 8'h99, 8'h00, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 8'hEF, 8'h00, 8'h99, 1'b1, 1'b0};
        vt[8]  = '{1'b1, 8'hF5, 8'h77, 8'h00, 1'b0, PROT};
        vt[9]  = '{1'b0, 8'hF5, 8'h00, 8'h77, !PROT, 1'b0};
        vt[10] = '{1'b1, 8'hFF, 8'h1E, 8'h00, 1'b0, PROT};
        vt[11] = '{1'b0, 8'hFF, 8'h00, 8'h1E, !PROT, 1'b0};
        vt[12] = '{1'b1, 8'h40, 8'h00, 8'h00, 1'b0, 1'b0};
        vt[13] = '{1'b0, 8'h40, 8'h00, 8'h00, 1'b1, 1'b0};

        reset = 1'b1; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        rd_hold = 8'h00; hold_valid = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        chk("reset_rdata", rdata, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        idle(5);

        // Directed table, applied back-to-back so each request is accepted from DONE.
        for (int i = 0; i < 14; i++) begin
            if (vt[i].wr) begin
                er = rd_hold; ev = hold_valid;
            end else begin
                er = vt[i].exp_rd; ev = vt[i].rd_valid;
            end
            do_access(vt[i].wr, vt[i].addr, vt[i].wdata, er, ev, vt[i].exp_err, 1'b0);
            if (!vt[i].wr) begin
                rd_hold = er; hold_valid = ev;
            end else if (!vt[i].exp_err) begin
                mdl[int'(vt[i].addr)] = vt[i].wdata;
            end
        end
        idle(2);

        // Alternating store/load with req pulses during WAIT that must be ignored.
        for (int i = 0; i < 3; i++) begin
            do_access(1'b1, 8'h20, 8'h33, rd_hold, hold_valid, 1'b0, 1'b1);
            mdl[32'h20] = 8'h33;
            do_access(1'b0, 8'h20, 8'h00, 8'h33, 1'b1, 1'b0, 1'b1);
            rd_hold = 8'h33; hold_valid = 1'b1;
        end
        idle(1);

        // Reset one cycle into WAIT discards the pending store and produces no done.
        req = 1'b1; wr = 1'b1; addr = 8'h40; wdata = 8'hAA;
        @(posedge clk); #1;
        chk("rst_wait_busy", busy, 1);
        req = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 0);
        rd_hold = 8'h00; hold_valid = 1'b1;
        @(posedge clk); #1;
        chk("rst_nodone", done, 0);
        chk("rst_idle_busy", busy, 0);
        do_access(1'b0, 8'h40, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Randomized accesses against the model; loads only target addresses with known contents.
        for (int i = 0; i < 200; i++) begin
            w = 1'($urandom);
            a = 8'($urandom);
            d = 8'($urandom);
            if (!w && !mdl.exists(int'(a))) w = 1'b1;
            if (w) begin
                rej = PROT && (a >= 8'hF0);
                do_access(1'b1, a, d, rd_hold, hold_valid, rej, 1'($urandom));
                if (!rej) mdl[int'(a)] = d;
            end else begin
                do_access(1'b0, a, 8'($urandom), mdl[int'(a)], 1'b1, 1'b0, 1'($urandom));
                rd_hold = mdl[int'(a)]; hold_valid = 1'b1;
            end
            idle(int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
